pio_poll_master: RTL and testbench
==================================

Name: pio_poll_master

Overview:
- Avalon-MM read initiator that periodically polls a single-register PIO input responder (32-bit readdata, registered, fixed read latency) and presents the sampled value to local fabric logic.
- Sits between the SoC interconnect and user logic. Removes the need for the Nios II to poll board-level inputs (keys, switches, reset button).
- Detects value changes and bit-0 edges, and flags stalled transactions.

Parameters:
- POLL_INTERVAL, 1000: clock cycles from one capture (or from reset) to the next automatic read request; legal range 2..65535.
- READ_LATENCY, 1: cycles from request acceptance to valid avm_readdata; legal range 1..4.
- TIMEOUT, 255: maximum cycles avm_read may be held under waitrequest before the request is abandoned; legal range 1..255.
- POLL_ADDR, 0: 2-bit word address driven on avm_address.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; allows automatic polling
- poll_now  in  1  one-cycle pulse; requests an immediate read
- avm_address  out  2  Avalon address, constant POLL_ADDR
- avm_read  out  1  Avalon read strobe
- avm_waitrequest  in  1  Avalon stall from interconnect
- avm_readdata  in  32  Avalon read data
- value  out  32  last captured readdata
- value_valid  out  1  high once at least one capture has completed
- changed  out  1  one-cycle pulse; new capture differs from previous value
- rise  out  1  one-cycle pulse; value[0] went 0->1
- fall  out  1  one-cycle pulse; value[0] went 1->0
- timeout_err  out  1  one-cycle pulse; a request was abandoned
- busy  out  1  high in REQ or LAT

Behaviour:
- Reset: reset_n is asynchronous and active-low; clk is the clock.
- While reset_n is low, all outputs are 0 except avm_address, which stays at POLL_ADDR. FSM goes to IDLE, interval counter clears to 0, latency and timeout counters clear, first-sample flag sets.
- FSM states: IDLE, REQ, LAT, CAP.
- IDLE:
  - Interval counter increments each cycle while enable=1.
  - Counter holds its value when enable=0; it does not clear.
  - Go to REQ when (enable=1 and counter == POLL_INTERVAL-1) or poll_now=1. poll_now is honoured even when enable=0.
  - Counter clears on that transition.
- REQ:
  - avm_read=1 and avm_address held stable.
  - Request is accepted on the first cycle with avm_waitrequest=0; go to LAT.
  - The timeout counter increments on every REQ cycle with waitrequest=1. If it reaches TIMEOUT, deassert avm_read next cycle, pulse timeout_err, and return to IDLE with no capture; value and value_valid are unchanged.
- LAT:
  - avm_read=0.
  - Count READ_LATENCY cycles starting from the acceptance edge. avm_readdata is sampled on the clock edge READ_LATENCY cycles after acceptance. With READ_LATENCY=1, sampling happens on the first clock edge in LAT.
  - Then go to CAP.
- CAP (one cycle):
  - value <= sampled data; value_valid <= 1.
  - changed, rise and fall are registered and assert in the cycle after the value update, for exactly one cycle.
  - First capture after reset: no change or edge pulses; the first-sample flag clears.
  - Then go to IDLE; the interval restarts from 0.
- poll_now while busy or in CAP is ignored. There is no queueing.
- Deasserting enable mid-transaction does not abort it; the read completes and captures.
- At most one outstanding read; pipelined reads are never issued.
- Comparison covers all 32 bits for changed; rise and fall use bit 0 only.
- A reset asserted mid-transaction abandons it immediately. No pulses are generated and value returns to 0.

Test Plan:
- Reset then enable=1, POLL_INTERVAL=8, slave returns 0x0 -> first avm_read asserts 8 cycles after enable; value_valid=1 after capture; changed, rise and fall all stay 0.
- Slave input toggles 0->1, then after the next poll 1->0 -> value 0x1 with changed and rise pulsed 1 cycle, then value 0x0 with changed and fall pulsed 1 cycle.
- avm_waitrequest held high 3 cycles during REQ -> avm_read and avm_address stable for 4 cycles; capture READ_LATENCY cycles after the waitrequest=0 edge; data 0xA5 captured.
- TIMEOUT=4, waitrequest stuck high -> avm_read drops after 4 stall cycles; timeout_err pulses once; value unchanged; next poll proceeds normally.
- enable=0, poll_now pulse -> single read issued and captured; a second poll_now during LAT is ignored (exactly one avm_read burst).
- reset_n asserted during LAT -> all outputs 0 asynchronously; after release, no stale capture and no pulses; polling resumes from counter 0.

Source files
------------

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that periodically polls a single PIO input register and
// presents the captured value with change/edge pulses and a stall timeout.
module pio_poll_master #(
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [1:0]  POLL_ADDR     = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        poll_now,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        changed,
  output logic        rise,
  output logic        fall,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StReq, StLat, StCap} state_e;

  state_e      state_q, state_d;
  logic [15:0] int_cnt_q, int_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] sample_q, sample_d;
  logic [31:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic        changed_q, changed_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;
  logic        to_err_q, to_err_d;

  always_comb begin
    state_d   = state_q;
    int_cnt_d = int_cnt_q;
    to_cnt_d  = to_cnt_q;
    lat_cnt_d = lat_cnt_q;
    sample_d  = sample_q;
    value_d   = value_q;
    valid_d   = valid_q;
    first_d   = first_q;
    changed_d = 1'b0;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    to_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (poll_now || (enable && int_cnt_q == 16'(POLL_INTERVAL - 1))) begin
          state_d   = StReq;
          int_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (enable) begin
          int_cnt_d = int_cnt_q + 16'd1;
        end
      end
      StReq: begin
        if (!avm_waitrequest) begin
          state_d   = StLat;
          lat_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (to_cnt_q == 8'(TIMEOUT - 1)) begin
          // This stall cycle is the TIMEOUT-th one: abandon without capture.
          state_d  = StIdle;
          to_err_d = 1'b1;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      StLat: begin
        if (lat_cnt_q == 2'(READ_LATENCY - 1)) begin
          sample_d = avm_readdata;
          state_d  = StCap;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      StCap: begin
        value_d = sample_q;
        valid_d = 1'b1;
        first_d = 1'b0;
        if (!first_q) begin
          changed_d = (sample_q != value_q);
          rise_d    = sample_q[0] & ~value_q[0];
          fall_d    = ~sample_q[0] & value_q[0];
        end
        state_d   = StIdle;
        int_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      int_cnt_q <= '0;
      to_cnt_q  <= '0;
      lat_cnt_q <= '0;
      sample_q  <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b1;
      changed_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_cnt_q <= int_cnt_d;
      to_cnt_q  <= to_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      sample_q  <= sample_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      changed_q <= changed_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      to_err_q  <= to_err_d;
    end
  end

  assign avm_address = POLL_ADDR;
  assign avm_read    = (state_q == StReq);
  assign busy        = (state_q == StReq) || (state_q == StLat);
  assign value       = value_q;
  assign value_valid = valid_q;
  assign changed     = changed_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Scoreboard bench for pio_poll_master: stimulus pushes expected captures/timeouts,
// a monitor pops and compares each time a transaction completes.
module tb_pio_poll_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        poll_now;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata = '0;
  logic [31:0] value;
  logic        value_valid;
  logic        changed;
  logic        rise;
  logic        fall;
  logic        timeout_err;
  logic        busy;

  logic        stuck;
  int          stall_len;
  int          stall_cnt = 0;
  logic [31:0] slave_val;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_to;
    logic [31:0] val;
    bit          ch;
    bit          r;
    bit          f;
  } exp_t;
  exp_t exp_q[$];

  pio_poll_master #(
    .POLL_INTERVAL(8),
    .READ_LATENCY (1),
    .TIMEOUT      (4),
    .POLL_ADDR    (2'b10)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .poll_now       (poll_now),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .value          (value),
    .value_valid    (value_valid),
    .changed        (changed),
    .rise           (rise),
    .fall           (fall),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Responder: optional stall, registered data valid only one cycle after acceptance.
  assign avm_waitrequest = stuck || (avm_read && (stall_cnt < stall_len));
  always @(posedge clk) begin
    if (!avm_read) stall_cnt <= 0;
    else if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
    avm_readdata <= (avm_read && !avm_waitrequest) ? slave_val : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_to, input logic [31:0] v, input bit ch, input bit r,
                      input bit f);
    exp_t e;
    e.is_to = is_to;
    e.val   = v;
    e.ch    = ch;
    e.r     = r;
    e.f     = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: %0d expected events still pending", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Returns the number of negedges until avm_read is seen high (0 if never).
  task automatic wait_read(output int n);
    int i = 0;
    n = 0;
    while (!avm_read && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (avm_read) n = i;
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_read: avm_read never asserted within 60 cycles");
    end
  endtask

  task automatic measure_burst(input string name, input int exp_len);
    int n;
    int len = 0;
    bit addr_ok = 1'b1;
    wait_read(n);
    while (avm_read && len < 20) begin
      if (avm_address !== 2'b10) addr_ok = 1'b0;
      len++;
      @(negedge clk);
    end
    check(name, 32'(len), 32'(exp_len));
    check({name, "_addr_stable"}, 32'(addr_ok), 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    bit prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_busy = 1'b0;
      end else if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: timeout_err=%0b value=%h, none expected",
                   timeout_err, value);
        end else begin
          e = exp_q.pop_front();
          check("event_is_timeout", 32'(timeout_err), 32'(e.is_to));
          if (e.is_to) begin
            check("timeout_value", value, e.val);
            check("timeout_valid", 32'(value_valid), 32'd1);
            @(negedge clk);
            check("timeout_err_width", 32'(timeout_err), 32'd0);
          end else begin
            @(negedge clk);
            check("cap_value", value, e.val);
            check("cap_valid", 32'(value_valid), 32'd1);
            check("cap_changed", 32'(changed), 32'(e.ch));
            check("cap_rise", 32'(rise), 32'(e.r));
            check("cap_fall", 32'(fall), 32'(e.f));
            @(negedge clk);
            check("pulse_width", {29'd0, changed, rise, fall}, 32'd0);
          end
        end
      end else if (changed || rise || fall || timeout_err) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_pulse: changed=%0b rise=%0b fall=%0b timeout_err=%0b",
                 changed, rise, fall, timeout_err);
      end
      prev_busy = reset_n && busy;
    end
  end

  initial begin : stimulus
    int n;
    int bursts;
    logic prev_rd;
    reset_n   = 1'b0;
    enable    = 1'b0;
    poll_now  = 1'b0;
    stuck     = 1'b0;
    stall_len = 0;
    slave_val = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {value, value_valid, changed, rise, fall, timeout_err, avm_read, busy}
                           == '0 ? 32'd0 : 32'd1, 32'd0);
    check("reset_address", 32'(avm_address), 32'd2);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // First automatic poll, 8 cycles after enable, no pulses on first sample.
    push(0, 32'h0, 0, 0, 0);
    enable = 1'b1;
    wait_read(n);
    check("first_read_delay", 32'(n), 32'd8);
    wait_done();

    slave_val = 32'h1;
    push(0, 32'h1, 1, 1, 0);
    wait_done();
    slave_val = 32'h0;
    push(0, 32'h0, 1, 0, 1);
    wait_done();
    push(0, 32'h0, 0, 0, 0);
    wait_done();

    // Three stall cycles before acceptance.
    slave_val = 32'hA5;
    stall_len = 3;
    push(0, 32'hA5, 1, 1, 0);
    measure_burst("stall_burst_len", 4);
    wait_done();
    stall_len = 0;

    // Stuck waitrequest: abandoned after 4 stall cycles, value kept.
    stuck = 1'b1;
    push(1, 32'hA5, 0, 0, 0);
    measure_burst("timeout_burst_len", 4);
    wait_done();
    stuck = 1'b0;
    slave_val = 32'hA4;
    push(0, 32'hA4, 1, 0, 1);
    wait_done();

    // Manual poll with enable low; a second poll_now during LAT/CAP is ignored.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    slave_val = 32'h3C;
    push(0, 32'h3C, 1, 0, 0);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    bursts  = 0;
    prev_rd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (avm_read && !prev_rd) bursts++;
      prev_rd = avm_read;
      if (i == 1) check("in_lat", {30'd0, avm_read, busy}, 32'd1);
      poll_now = (i == 1 || i == 2);
      @(negedge clk);
    end
    poll_now = 1'b0;
    check("manual_bursts", 32'(bursts), 32'd1);
    wait_done();

    // Reset during LAT abandons the read.
    slave_val = 32'hFF;
    poll_now  = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_read(n);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {value, value_valid, changed, rise, fall, timeout_err, avm_read, busy} == '0
          ? 32'd0 : 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_value", value, 32'h0);
    check("post_reset_valid", 32'(value_valid), 32'd0);
    push(0, 32'hFF, 0, 0, 0);
    enable = 1'b1;
    wait_read(n);
    check("post_reset_read_delay", 32'(n), 32'd8);
    wait_done();
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
